// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer, bus responder for the mips bridge.
// Registers (word offset): 0 CTRL {IM, Mode[1:0], En}, 1 PRESET, 2 COUNT (RO), 3 reserved.
// Optional feature macro: TIMER_AUTO_RELOAD_EN enables Mode 01 (auto-reload);
// without it the Mode bits are not stored and every expiry is one-shot.
//
// state | meaning
// IDLE  | waiting for En
// LOAD  | COUNT <= PRESET
// CNT   | counting down while En stays set
// INT   | expiry: raise irq_flag, then reload or stop
module timer_dev #(
   parameter logic [31:0] PRESET_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  Addr,
   input  logic        WeDev,
   input  logic [31:0] DIn,
   output logic [31:0] DOut,
   output logic        IRQ
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] CNT  = 2'd2;
   localparam logic [1:0] INT  = 2'd3;

   logic [1:0]  state_q, state_d;
   logic        en_q, en_d;
   logic        im_q, im_d;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        irq_flag_q, irq_flag_d;
   logic [1:0]  mode_rd;
   logic        auto_mode;
   logic        we_ctrl, we_preset;

   assign we_ctrl   = WeDev && (Addr == 2'd0);
   assign we_preset = WeDev && (Addr == 2'd1);

`ifdef TIMER_AUTO_RELOAD_EN
   logic [1:0] mode_q, mode_d;

   // Mode field storage, only present when auto-reload is built in
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mode_q <= 2'b00;
      else     mode_q <= mode_d;
   end

   always_comb begin
      mode_d = mode_q;
      if (we_ctrl) mode_d = DIn[2:1];
   end

   assign mode_rd   = mode_q;
   assign auto_mode = (mode_q == 2'b01);
`else
   assign mode_rd   = 2'b00;
   assign auto_mode = 1'b0;
`endif

   // Next-state, counter, interrupt flag and register-write logic
   always_comb begin
      state_d    = state_q;
      en_d       = en_q;
      im_d       = im_q;
      preset_d   = preset_q;
      count_d    = count_q;
      irq_flag_d = irq_flag_q;

      // Any CTRL/PRESET write clears the flag; an expiry in the same cycle still sets it.
      if (we_ctrl || we_preset) irq_flag_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (en_q) state_d = LOAD;
         end
         LOAD: begin
            count_d = preset_q;
            state_d = CNT;
            // The auto-reload pulse lasts only the cycle after INT.
            if (auto_mode) irq_flag_d = 1'b0;
         end
         CNT: begin
            if (!en_q) begin
               state_d = IDLE;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               count_d = 32'd0;
               state_d = INT;
            end
         end
         default: begin
            irq_flag_d = 1'b1;
            if (auto_mode) begin
               state_d = LOAD;
            end else begin
               state_d = IDLE;
               en_d    = 1'b0;
            end
         end
      endcase

      // Bus writes come last so they win over the hardware clear of En.
      if (we_ctrl) begin
         en_d = DIn[0];
         im_d = DIn[3];
      end
      if (we_preset) preset_d = DIn;
   end

   // State and register flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         en_q       <= 1'b0;
         im_q       <= 1'b0;
         preset_q   <= PRESET_RESET;
         count_q    <= 32'd0;
         irq_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         en_q       <= en_d;
         im_q       <= im_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
      end
   end

   // Zero-latency read mux
   always_comb begin
      case (Addr)
         2'd0:    DOut = {28'd0, im_q, mode_rd, en_q};
         2'd1:    DOut = preset_q;
         2'd2:    DOut = count_q;
         default: DOut = 32'd0;
      endcase
   end

   assign IRQ = im_q & irq_flag_q;

endmodule

// File: tb/tb_timer_dev.sv
// Directed testbench for timer_dev; expected values are hand-derived from the timer's timing.
module tb_timer_dev;

   logic        clk;
   logic        rst;
   logic [1:0]  Addr;
   logic        WeDev;
   logic [31:0] DIn;
   logic [31:0] DOut;
   logic        IRQ;

   int n_tests;
   int n_fail;

   timer_dev #(.PRESET_RESET(32'h0)) dut (
      .clk   (clk),
      .rst   (rst),
      .Addr  (Addr),
      .WeDev (WeDev),
      .DIn   (DIn),
      .DOut  (DOut),
      .IRQ   (IRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, ending 1 ns after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Bus write landing on the next rising edge; returns 1 ns after it.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      Addr  = a;
      DIn   = d;
      WeDev = 1'b1;
      @(posedge clk);
      #1;
      WeDev = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      Addr = a;
      #1;
      d = DOut;
   endtask

   logic [31:0] v;
   logic        exp_irq;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      WeDev   = 1'b0;
      Addr    = 2'd0;
      DIn     = 32'd0;

      // Reset values of all four offsets
      rd(2'd0, v); check("rst_ctrl", v, 32'h0);
      rd(2'd1, v); check("rst_preset", v, 32'h0);
      rd(2'd2, v); check("rst_count", v, 32'h0);
      rd(2'd3, v); check("rst_rsvd", v, 32'h0);
      check("rst_irq", {31'd0, IRQ}, 32'd0);
      #1 rst = 1'b0;
      tick(2);

      // One-shot, PRESET = 5
      wr(2'd1, 32'd5);
      rd(2'd1, v); check("preset_rb", v, 32'd5);
      wr(2'd0, 32'h9);
      tick(2);  rd(2'd2, v); check("os_count_e2", v, 32'd5);
      tick(4);  rd(2'd2, v); check("os_count_e6", v, 32'd1);
      tick(1);  check("os_irq_e7", {31'd0, IRQ}, 32'd0);
      tick(1);  check("os_irq_e8", {31'd0, IRQ}, 32'd1);
      rd(2'd0, v); check("os_ctrl_e8", v, 32'h8);
      tick(3);  check("os_irq_sticky", {31'd0, IRQ}, 32'd1);
      wr(2'd0, 32'h0);
      check("os_irq_clr", {31'd0, IRQ}, 32'd0);
      tick(2);

      // Mode 01, PRESET = 3: pulses after edges 6, 11, 16, 21 (or sticky from 6 when one-shot only)
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);
      for (int k = 1; k <= 22; k++) begin
         tick(1);
`ifdef TIMER_AUTO_RELOAD_EN
         exp_irq = (k >= 6) && (((k - 6) % 5) == 0);
`else
         exp_irq = (k >= 6);
`endif
         check($sformatf("ar_irq_e%0d", k), {31'd0, IRQ}, {31'd0, exp_irq});
      end
      rd(2'd0, v);
`ifdef TIMER_AUTO_RELOAD_EN
      check("ar_ctrl", v, 32'hB);
`else
      check("ar_ctrl", v, 32'h8);
`endif
      wr(2'd0, 32'h0);
      tick(6);

      // Masked expiry, then a CTRL write clears the hidden flag
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h1);
      tick(8);  check("mask_irq_e8", {31'd0, IRQ}, 32'd0);
      rd(2'd0, v); check("mask_ctrl", v, 32'h0);
      wr(2'd0, 32'h8);
      tick(2);  check("mask_irq_after_im", {31'd0, IRQ}, 32'd0);
      wr(2'd0, 32'h0);
      tick(2);

      // Stop mid-count: En cleared at the edge where COUNT becomes 6
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h9);
      tick(5);  rd(2'd2, v); check("stop_count_e5", v, 32'd7);
      wr(2'd0, 32'h0);
      tick(3);  rd(2'd2, v); check("stop_count_hold", v, 32'd6);
      check("stop_irq", {31'd0, IRQ}, 32'd0);

      // PRESET = 0 behaves as 1: IRQ after 4 edges
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h9);
      tick(2);  rd(2'd2, v); check("p0_count_e2", v, 32'd0);
      tick(1);  check("p0_irq_e3", {31'd0, IRQ}, 32'd0);
      tick(1);  check("p0_irq_e4", {31'd0, IRQ}, 32'd1);
      wr(2'd0, 32'h0);
      tick(2);

      // CTRL write in the INT cycle: bus keeps En set, flag still sets
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h9);
      tick(4);
      wr(2'd0, 32'h9);
      check("race_irq", {31'd0, IRQ}, 32'd1);
      rd(2'd0, v); check("race_ctrl", v, 32'h9);
      tick(3);  check("race_irq_sticky", {31'd0, IRQ}, 32'd1);
      wr(2'd0, 32'h0);
      tick(2);

      // Asynchronous reset mid-count
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h9);
      tick(8);  rd(2'd2, v); check("ar_pre_count", v, 32'd4);
      rst = 1'b1;
      #1;
      check("arst_irq", {31'd0, IRQ}, 32'd0);
      rd(2'd2, v); check("arst_count", v, 32'd0);
      rd(2'd0, v); check("arst_ctrl", v, 32'h0);
      rd(2'd1, v); check("arst_preset", v, 32'h0);
      #3 rst = 1'b0;
      tick(4);
      rd(2'd2, v); check("arst_idle_count", v, 32'd0);
      check("arst_idle_irq", {31'd0, IRQ}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
